// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the SimpleMIPS pipeline control unit.
// Optional performance counters in the top are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    localparam logic STALL  = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int unsigned PERF_W = 32;

    typedef enum logic {
        PC_RUN   = 1'b0,
        PC_FLUSH = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_enc.sv
// Priority encoder: highest active stall request -> thermometer stall mask
// (bit 0 = PC) and one-hot bubble just below the highest stalled stage.
module pipe_ctrl_enc
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ:0]   stall_o,
    output logic [NREQ:0]   bubble_o
);

    logic        found;
    int unsigned h;

    always_comb begin
        found    = 1'b0;
        h        = 0;
        stall_o  = '0;
        bubble_o = '0;
        // Ascending scan: the last hit is the highest index.
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (req_i[k]) begin
                found = 1'b1;
                h     = k;
            end
        end
        for (int unsigned j = 0; j <= NREQ; j++) begin
            stall_o[j]  = (found && (j <= h + 1)) ? STALL : NOSTOP;
            bubble_o[j] = found && (j == h + 2);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: NREQ-source stall encoding, multi-cycle flush FSM, stall
// watchdog. Define PIPE_CTRL_PERF_EN to add stall_cnt/flush_cnt counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned WD_W      = 8,
    parameter int unsigned WD_LIMIT  = 200
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst,
    input  logic [NREQ-1:0]          stallreq,
    input  logic                     flushreq,
    input  logic                     wd_clr,
    output logic [NREQ:0]            stall,
    output logic [NREQ:0]            bubble,
    output logic                     flush,
    output logic                     busy_flush,
    output logic                     stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [NREQ*PERF_W-1:0]   stall_cnt,
    output logic [PERF_W-1:0]        flush_cnt
`endif
);

    localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);
    localparam logic [WD_W-1:0] WD_HIT  = WD_W'(WD_LIMIT - 1);

    pc_state_e       state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    logic            wd_hit;

    logic [NREQ:0]   enc_stall;
    logic [NREQ:0]   enc_bubble;

    pipe_ctrl_enc #(
        .NREQ(NREQ)
    ) u_enc (
        .req_i   (stallreq),
        .stall_o (enc_stall),
        .bubble_o(enc_bubble)
    );

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q <= PC_RUN;
            fcnt_q  <= '0;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        wd_d       = wd_q;
        wd_hit     = 1'b0;
        stall      = '0;
        bubble     = '0;
        flush      = 1'b0;
        busy_flush = 1'b0;
        case (state_q)
            PC_RUN: begin
                stall  = enc_stall;
                bubble = enc_bubble;
                if (flushreq) begin
                    state_d = PC_FLUSH;
                    fcnt_d  = FC_LOAD;
                end
                if (|enc_stall) begin
                    if (wd_q != '1) wd_d = wd_q + WD_W'(1);
                    wd_hit = (wd_q == WD_HIT);
                end else begin
                    wd_d = '0;
                end
            end
            PC_FLUSH: begin
                flush      = 1'b1;
                busy_flush = 1'b1;
                wd_d       = '0;
                if (flushreq)           fcnt_d  = FC_LOAD;
                else if (fcnt_q == '0)  state_d = PC_RUN;
                else                    fcnt_d  = fcnt_q - FC_W'(1);
            end
            default: state_d = PC_RUN;
        endcase
        // Clear beats a coincident watchdog hit.
        if (wd_clr)      to_d = 1'b0;
        else if (wd_hit) to_d = 1'b1;
        else             to_d = to_q;
    end

    assign stall_timeout = to_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] scnt_q [NREQ];
    logic [PERF_W-1:0] fl_cnt_q;
    logic [NREQ+1:0]   st_ext;

    assign st_ext = {1'b0, enc_stall};

    // Source k is the highest request exactly where the thermometer ends at k+1.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            for (int unsigned k = 0; k < NREQ; k++) scnt_q[k] <= '0;
            fl_cnt_q <= '0;
        end else if (state_q == PC_RUN) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (st_ext[k+1] && !st_ext[k+2]) scnt_q[k] <= scnt_q[k] + PERF_W'(1);
            end
            if (flushreq) fl_cnt_q <= fl_cnt_q + PERF_W'(1);
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int unsigned k = 0; k < NREQ; k++) stall_cnt[k*PERF_W +: PERF_W] = scnt_q[k];
    end

    assign flush_cnt = fl_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (NREQ=3, FLUSH_CYC=2, WD_LIMIT=200).
// Perf counter checks are included when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

    logic       cpu_clk_50M = 1'b0;
    logic       cpu_rst     = 1'b1;
    logic [2:0] stallreq    = '0;
    logic       flushreq    = 1'b0;
    logic       wd_clr      = 1'b0;
    logic [3:0] stall;
    logic [3:0] bubble;
    logic       flush;
    logic       busy_flush;
    logic       stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [95:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    pipe_ctrl #(
        .NREQ     (3),
        .FLUSH_CYC(2),
        .WD_W     (8),
        .WD_LIMIT (200)
    ) dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst      (cpu_rst),
        .stallreq     (stallreq),
        .flushreq     (flushreq),
        .wd_clr       (wd_clr),
        .stall        (stall),
        .bubble       (bubble),
        .flush        (flush),
        .busy_flush   (busy_flush),
        .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1, checks happen at posedge+2.
    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    initial begin
        tick();
        tick();
        #1;
        check("rst_stall", stall, 4'b0000);
        check("rst_bubble", bubble, 4'b0000);
        check("rst_flush", flush, 1'b0);
        check("rst_busy", busy_flush, 1'b0);
        check("rst_timeout", stall_timeout, 1'b0);
        cpu_rst = 1'b0;
        tick();

        // Single mid-stage request held three cycles, then released.
        stallreq = 3'b010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s010_stall", stall, 4'b0111);
            check("s010_bubble", bubble, 4'b1000);
            tick();
        end
        stallreq = 3'b000;
        #1;
        check("rel_stall", stall, 4'b0000);
        check("rel_bubble", bubble, 4'b0000);
        tick();

        stallreq = 3'b101;
        #1;
        check("s101_stall", stall, 4'b1111);
        check("s101_bubble", bubble, 4'b0000);
        tick();
        stallreq = 3'b001;
        #1;
        check("s001_stall", stall, 4'b0011);
        check("s001_bubble", bubble, 4'b0100);
        tick();
        stallreq = 3'b011;
        #1;
        check("s011_stall", stall, 4'b0111);
        check("s011_bubble", bubble, 4'b1000);
        tick();
        stallreq = 3'b000;
        tick();

        // Flush pulse with deepest stall held.
        stallreq = 3'b100;
        flushreq = 1'b1;
        #1;
        check("fl_c10_stall", stall, 4'b1111);
        check("fl_c10_flush", flush, 1'b0);
        tick();
        flushreq = 1'b0;
        #1;
        check("fl_c11_flush", flush, 1'b1);
        check("fl_c11_busy", busy_flush, 1'b1);
        check("fl_c11_stall", stall, 4'b0000);
        check("fl_c11_bubble", bubble, 4'b0000);
        tick();
        #1;
        check("fl_c12_flush", flush, 1'b1);
        check("fl_c12_stall", stall, 4'b0000);
        tick();
        #1;
        check("fl_c13_flush", flush, 1'b0);
        check("fl_c13_busy", busy_flush, 1'b0);
        check("fl_c13_stall", stall, 4'b1111);
        tick();

        // Re-request during FLUSH extends it.
        flushreq = 1'b1;
        tick();
        flushreq = 1'b0;
        #1;
        check("rf_c11_flush", flush, 1'b1);
        tick();
        flushreq = 1'b1;
        #1;
        check("rf_c12_flush", flush, 1'b1);
        tick();
        flushreq = 1'b0;
        #1;
        check("rf_c13_flush", flush, 1'b1);
        tick();
        #1;
        check("rf_c14_flush", flush, 1'b1);
        tick();
        #1;
        check("rf_c15_flush", flush, 1'b0);
        check("rf_c15_stall", stall, 4'b1111);
        stallreq = 3'b000;
        tick();

        // Watchdog: 250 stalled cycles, timeout visible from cycle 201.
        stallreq = 3'b001;
        for (int i = 1; i <= 250; i++) begin
            #1;
            if (i == 200) check("wd_c200", stall_timeout, 1'b0);
            if (i == 201) check("wd_c201", stall_timeout, 1'b1);
            if (i == 250) check("wd_c250", stall_timeout, 1'b1);
            tick();
        end
        wd_clr = 1'b1;
        #1;
        check("wd_clr_same", stall_timeout, 1'b1);
        tick();
        wd_clr = 1'b0;
        #1;
        check("wd_clr_next", stall_timeout, 1'b0);
        tick();
        tick();
        #1;
        check("wd_clr_stays", stall_timeout, 1'b0);
        stallreq = 3'b000;
        tick();

        // 199 stalled cycles never time out; clear on the would-be hit wins.
        stallreq = 3'b001;
        for (int i = 1; i <= 199; i++) tick();
        #1;
        check("wd_199", stall_timeout, 1'b0);
        wd_clr = 1'b1;
        tick();
        wd_clr = 1'b0;
        #1;
        check("wd_clr_wins", stall_timeout, 1'b0);
        stallreq = 3'b000;
        tick();
        #1;
        check("wd_idle", stall_timeout, 1'b0);

        // Reset during the first FLUSH cycle.
        flushreq = 1'b1;
        tick();
        flushreq = 1'b0;
        #1;
        check("rf1_flush", flush, 1'b1);
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        #1;
        check("rmf_flush", flush, 1'b0);
        check("rmf_busy", busy_flush, 1'b0);
        check("rmf_stall", stall, 4'b0000);
        tick();

        stallreq = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("post_rst_stall", stall, 4'b0111);
            tick();
        end
        stallreq = 3'b000;
        #1;
`ifdef PIPE_CTRL_PERF_EN
        check("perf_cnt0", stall_cnt[31:0], 32'd0);
        check("perf_cnt1", stall_cnt[63:32], 32'd5);
        check("perf_cnt2", stall_cnt[95:64], 32'd0);
        check("perf_flush", flush_cnt, 32'd0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
